ecm_emm_fetch: RTL and testbench
================================

Name: ecm_emm_fetch

Overview:
- Channel-side consumer of the ECM/EMM injection buffer.
- Watches the injector's payload request and raises chan_out_req. It then captures the 48-word payload burst (one tag word plus 47 words holding a 188-byte TS packet) and checks its framing.
- Validated packets are serialized as a byte stream with a valid/ready handshake toward the TS output mux. Single clock domain (the injector's read clock).

Parameters:
- WORD_NUM, 48, words per burst, including the tag word.
- ACK_TIMEOUT, 255, maximum cycles from the chan_out_req rise to chan_out_ack.
- REQ_GUARD, 4, cycles after leaving a fetch before payload_req_in is sampled again.

Ports:
- clk  input  1  system clock (125 MHz).
- rst  input  1  synchronous, active-high reset.
- payload_req_in  input  1  injector has at least one packet queued.
- chan_out_req  output  1  fetch request (level); the injector triggers on the rising edge.
- chan_out_ack  input  1  one-cycle pulse from the injector, coincident with the last word.
- payload_in_valid  input  1  data word valid.
- payload_in_start  input  1  first word of the burst.
- payload_in_end  input  1  last word of the burst.
- payload_in_data  input  32  burst word.
- ts_out_ready  input  1  downstream accepts a byte.
- ts_out_valid  output  1  byte valid.
- ts_out_data  output  8  TS byte.
- ts_out_sop  output  1  byte 0 of the packet.
- ts_out_eop  output  1  byte 187 of the packet.
- pkt_tag  output  32  tag word of the packet currently being sent.
- fetch_err  output  1  one-cycle error pulse.
- pkt_cnt  output  16  count of packets fully sent; wraps 0xFFFF to 0.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; guard counter loaded with REQ_GUARD; internal buffer contents don't-care.
- FSM states: IDLE, REQ, RECV, SEND.
- IDLE:
  - Guard counter decrements to 0.
  - When guard==0 and payload_req_in==1: go to REQ, set chan_out_req=1 next cycle, clear the word index and the timeout counter.
- REQ / RECV:
  - chan_out_req is held high; the timeout counter increments each cycle.
  - A valid word with start=1 sets index 0, captures the word into pkt_tag_shadow, and moves the FSM to RECV.
  - Valid words with index 1..47 are stored in the 47x32 buffer at index-1; the index then increments.
- Big-endian byte order: data[31:24] is the first byte on the wire.
- Completion, when chan_out_ack==1:
  - The last word (valid, end, ack all in the same cycle) must land at index WORD_NUM-1.
  - Buffer byte 0 must equal 0x47.
  - If both hold: chan_out_req drops next cycle, pkt_tag is loaded from the shadow, the FSM goes to SEND.
  - If either fails: fetch_err pulses, the data is dropped, and the FSM returns to IDLE.
- Framing errors: fetch_err pulse, chan_out_req low, return to IDLE, guard reloaded.
  - valid before any start.
  - start when index != 0.
  - end without ack, or ack without end.
  - index overflow past WORD_NUM-1.
  - Timeout counter reaching ACK_TIMEOUT.
- The burst from an aborted fetch is absorbed and ignored. Valid words arriving in IDLE or SEND are ignored and produce no error.
- chan_out_req stays low for at least REQ_GUARD cycles between requests. This guarantees a clean rising edge and lets the injector's stale payload_req settle.
- SEND:
  - The byte counter runs 0..187. ts_out_valid=1 and ts_out_data = buffer byte[counter].
  - The counter advances only on valid & ready. While ready==0, data, sop and eop are held stable.
  - sop=1 when counter==0; eop=1 when counter==187.
  - Latency: ts_out_valid rises on the cycle after the chan_out_ack cycle.
- End of packet: on the eop handshake, pkt_cnt increments, ts_out_valid drops next cycle, the guard is reloaded and the FSM returns to IDLE.
- Reset mid-operation: any state goes to IDLE at the next clk edge. chan_out_req and ts_out_valid are low the following cycle, and any partial packet is discarded.

Test Plan:
- Clean burst: payload_req_in=1; the injector model answers the chan_out_req rise with 48 words (tag 0xA5A50001, bytes 0x47,0x01,0x02,...), with end and ack on word 48 -> chan_out_req is high exactly until the ack cycle +1; 188 bytes out, sop on 0x47, eop on byte 187; pkt_tag=0xA5A50001; pkt_cnt=1.
- Backpressure: ts_out_ready toggles 1,0,0,1 throughout SEND -> no byte is lost or duplicated; data is stable while ready=0; exactly 188 handshakes.
- Short burst: end and ack arrive on word 40 -> fetch_err pulses once; no ts_out_valid; chan_out_req low for at least 4 cycles before the next request.
- Bad sync: byte 0 is 0x00 -> fetch_err pulses; the packet is dropped; pkt_cnt is unchanged.
- Timeout: no ack for 255 cycles after the request -> fetch_err at cycle 255; chan_out_req falls; the next request re-rises only after the guard expires.
- Reset at SEND byte 90 -> the cycle after reset, ts_out_valid=0 and pkt_cnt=0; the next fetch completes normally.

Source files
------------

// File: rtl/ecm_emm_fetch.sv
// ECM/EMM payload fetcher: pulls a tagged burst from the injection buffer,
// checks its framing and replays the TS packet as a byte stream.
module ecm_emm_fetch #(
    parameter int WORD_NUM    = 48,
    parameter int ACK_TIMEOUT = 255,
    parameter int REQ_GUARD   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        payload_req_in,
    output logic        chan_out_req,
    input  logic        chan_out_ack,
    input  logic        payload_in_valid,
    input  logic        payload_in_start,
    input  logic        payload_in_end,
    input  logic [31:0] payload_in_data,
    input  logic        ts_out_ready,
    output logic        ts_out_valid,
    output logic [7:0]  ts_out_data,
    output logic        ts_out_sop,
    output logic        ts_out_eop,
    output logic [31:0] pkt_tag,
    output logic        fetch_err,
    output logic [15:0] pkt_cnt
);

    localparam int PKT_BYTES = (WORD_NUM - 1) * 4;
    localparam int IW = $clog2(WORD_NUM + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int GW = $clog2(REQ_GUARD + 1);
    localparam int BW = $clog2(PKT_BYTES);
    localparam int AW = BW - 2;

    typedef enum logic [1:0] {IDLE, REQ, RECV, SEND} state_t;

    state_t        state, state_nx;
    logic [GW-1:0] guard;
    logic [IW-1:0] idx;
    logic [TW-1:0] tmo;
    logic [BW-1:0] byte_cnt;
    logic [31:0]   tag_shadow;
    logic [31:0]   pkt_mem [WORD_NUM-1];
    logic [AW-1:0] wr_addr;
    logic [31:0]   rd_word;
    logic          err, done, wr, take_tag;
    logic          last_ok, last_byte;

    assign wr_addr   = AW'(idx - 1'b1);
    assign last_byte = (byte_cnt == BW'(PKT_BYTES - 1));
    assign last_ok   = chan_out_ack && payload_in_valid && payload_in_end
                       && !payload_in_start && (state == RECV)
                       && (idx == IW'(WORD_NUM - 1))
                       && (pkt_mem[0][31:24] == 8'h47);

    always_comb begin
        state_nx = state;
        err      = 1'b0;
        done     = 1'b0;
        wr       = 1'b0;
        take_tag = 1'b0;
        unique case (state)
            IDLE: if (guard == '0 && payload_req_in) state_nx = REQ;
            REQ, RECV: begin
                // end and ack must coincide; either one alone is a framing error
                if (chan_out_ack || (payload_in_valid && payload_in_end)) begin
                    if (last_ok) done = 1'b1;
                    else         err  = 1'b1;
                end else if (payload_in_valid) begin
                    if (payload_in_start) begin
                        if (idx == '0) take_tag = 1'b1;
                        else           err      = 1'b1;
                    end else if (state == REQ || idx > IW'(WORD_NUM - 1)) begin
                        err = 1'b1;
                    end else begin
                        wr = 1'b1;
                    end
                end
                if (!done && tmo == TW'(ACK_TIMEOUT - 1)) err = 1'b1;
                if (err)           state_nx = IDLE;
                else if (done)     state_nx = SEND;
                else if (take_tag) state_nx = RECV;
            end
            SEND: if (ts_out_ready && last_byte) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            guard      <= GW'(REQ_GUARD);
            idx        <= '0;
            tmo        <= '0;
            byte_cnt   <= '0;
            tag_shadow <= '0;
            pkt_tag    <= '0;
            fetch_err  <= 1'b0;
            pkt_cnt    <= '0;
        end else begin
            state     <= state_nx;
            fetch_err <= err;
            unique case (state)
                IDLE: begin
                    if (guard != '0) guard <= guard - 1'b1;
                    idx <= '0;
                    tmo <= '0;
                end
                REQ, RECV: begin
                    tmo <= tmo + 1'b1;
                    if (take_tag) begin
                        tag_shadow <= payload_in_data;
                        idx        <= IW'(1);
                    end
                    if (wr) idx <= idx + 1'b1;
                    if (err) guard <= GW'(REQ_GUARD);
                    if (done) begin
                        pkt_tag  <= tag_shadow;
                        byte_cnt <= '0;
                    end
                end
                SEND: begin
                    if (ts_out_ready) begin
                        if (last_byte) begin
                            byte_cnt <= '0;
                            pkt_cnt  <= pkt_cnt + 1'b1;
                            guard    <= GW'(REQ_GUARD);
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // payload storage needs no reset; contents are only read after a full burst
    always_ff @(posedge clk) begin
        if (wr || done) pkt_mem[wr_addr] <= payload_in_data;
    end

    assign rd_word = pkt_mem[byte_cnt[BW-1:2]];

    always_comb begin
        case (byte_cnt[1:0])
            2'd0:    ts_out_data = rd_word[31:24];
            2'd1:    ts_out_data = rd_word[23:16];
            2'd2:    ts_out_data = rd_word[15:8];
            default: ts_out_data = rd_word[7:0];
        endcase
    end

    assign chan_out_req = (state == REQ) || (state == RECV);
    assign ts_out_valid = (state == SEND);
    assign ts_out_sop   = (state == SEND) && (byte_cnt == '0);
    assign ts_out_eop   = (state == SEND) && last_byte;

endmodule

// File: tb/tb_ecm_emm_fetch.sv
// Randomized bench for ecm_emm_fetch: an injector model feeds bursts and a
// packet-level reference predicts bytes, errors and counters.
module tb_ecm_emm_fetch;

    localparam int WORD_NUM    = 48;
    localparam int ACK_TIMEOUT = 255;
    localparam int REQ_GUARD   = 4;
    localparam int NB          = (WORD_NUM - 1) * 4;

    localparam int K_GOOD    = 0;
    localparam int K_SHORT   = 1;
    localparam int K_SYNC    = 2;
    localparam int K_NOSTART = 3;
    localparam int K_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        payload_req_in;
    logic        chan_out_req;
    logic        chan_out_ack;
    logic        payload_in_valid;
    logic        payload_in_start;
    logic        payload_in_end;
    logic [31:0] payload_in_data;
    logic        ts_out_ready;
    logic        ts_out_valid;
    logic [7:0]  ts_out_data;
    logic        ts_out_sop;
    logic        ts_out_eop;
    logic [31:0] pkt_tag;
    logic        fetch_err;
    logic [15:0] pkt_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          err_seen = 0;
    int          valid_seen = 0;
    int          low_run  = 0;
    int          last_gap = 0;
    logic [15:0] exp_cnt  = '0;

    ecm_emm_fetch #(
        .WORD_NUM(WORD_NUM),
        .ACK_TIMEOUT(ACK_TIMEOUT),
        .REQ_GUARD(REQ_GUARD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .payload_req_in(payload_req_in),
        .chan_out_req(chan_out_req),
        .chan_out_ack(chan_out_ack),
        .payload_in_valid(payload_in_valid),
        .payload_in_start(payload_in_start),
        .payload_in_end(payload_in_end),
        .payload_in_data(payload_in_data),
        .ts_out_ready(ts_out_ready),
        .ts_out_valid(ts_out_valid),
        .ts_out_data(ts_out_data),
        .ts_out_sop(ts_out_sop),
        .ts_out_eop(ts_out_eop),
        .pkt_tag(pkt_tag),
        .fetch_err(fetch_err),
        .pkt_cnt(pkt_cnt)
    );

    always #4 clk = ~clk;

    // event counters and low-time of chan_out_req before each rise
    always @(negedge clk) begin
        if (fetch_err === 1'b1) err_seen++;
        if (ts_out_valid === 1'b1) valid_seen++;
        if (chan_out_req === 1'b1) begin
            if (low_run != 0) last_gap = low_run;
            low_run = 0;
        end else begin
            low_run++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rise(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (chan_out_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic fetch(input int kind, input bit fixed, input int bp,
                         input int rst_at);
        logic [7:0]  pl [NB];
        logic [7:0]  got [$];
        logic [31:0] tag;
        logic [9:0]  held;
        int          e0, v0, g, nw, hs, mism, flags, unstable, badv, n, b;
        bit          ok, fin, hold, r;

        g = 0; hs = 0; mism = 0; flags = 0; unstable = 0; badv = 0;
        fin = 1'b0; hold = 1'b0; held = '0;
        tag = fixed ? 32'hA5A50001 : $urandom;
        for (int i = 0; i < NB; i++) pl[i] = fixed ? 8'(i) : 8'($urandom);
        pl[0] = (kind == K_SYNC) ? 8'h00 : 8'h47;
        e0 = err_seen;
        v0 = valid_seen;

        wait_rise(ok);
        check("req_rise", 32'(ok), 32'd1);

        if (kind == K_TIMEOUT) begin
            n = 0;
            while (chan_out_req === 1'b1 && n < 400) begin
                tick();
                n++;
                if (n == 1) g = last_gap;
            end
            check("req_gap", 32'(g >= REQ_GUARD), 32'd1);
            check("tmo_len", n, ACK_TIMEOUT);
            check("tmo_err", 32'(fetch_err), 32'd1);
            tick();
            tick();
            check("err_once", err_seen - e0, 32'd1);
            check("no_valid", valid_seen - v0, 32'd0);
            return;
        end

        if (kind == K_NOSTART) payload_req_in = 1'b0;
        tick();
        g = last_gap;
        repeat ($urandom_range(0, 3)) tick();

        nw = (kind == K_SHORT) ? 40 : WORD_NUM;
        for (int w = 0; w < nw; w++) begin
            if ($urandom_range(0, 3) == 0) tick();
            b = 4 * (w - 1);
            payload_in_valid = 1'b1;
            payload_in_start = (w == 0) && (kind != K_NOSTART);
            payload_in_end   = (w == nw - 1);
            chan_out_ack     = (w == nw - 1);
            if (w == 0) payload_in_data = tag;
            else payload_in_data = {pl[b], pl[b+1], pl[b+2], pl[b+3]};
            if (w == nw - 1 && kind == K_GOOD)
                check("req_at_ack", 32'(chan_out_req), 32'd1);
            tick();
            payload_in_valid = 1'b0;
            payload_in_start = 1'b0;
            payload_in_end   = 1'b0;
            chan_out_ack     = 1'b0;
            payload_in_data  = $urandom;
        end
        payload_req_in = 1'b1;
        check("req_gap", 32'(g >= REQ_GUARD), 32'd1);

        if (kind != K_GOOD) begin
            tick();
            tick();
            check("err_once", err_seen - e0, 32'd1);
            check("no_valid", valid_seen - v0, 32'd0);
            check("cnt_hold", 32'(pkt_cnt), 32'(exp_cnt));
            return;
        end

        check("req_drop", 32'(chan_out_req), 32'd0);
        check("valid_rise", 32'(ts_out_valid), 32'd1);
        check("tag", pkt_tag, tag);

        for (int c = 0; c < 2000 && !fin; c++) begin
            if (rst_at >= 0 && hs == rst_at) begin
                ts_out_ready = 1'b0;
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check("rst_valid", 32'(ts_out_valid), 32'd0);
                check("rst_cnt", 32'(pkt_cnt), 32'd0);
                check("rst_req", 32'(chan_out_req), 32'd0);
                exp_cnt = '0;
                return;
            end
            case (bp)
                0:       r = 1'b1;
                1:       r = (c % 4 == 0) || (c % 4 == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            ts_out_ready = r;
            if (ts_out_valid !== 1'b1) badv++;
            if (hold && {ts_out_data, ts_out_sop, ts_out_eop} !== held)
                unstable++;
            if (r) begin
                got.push_back(ts_out_data);
                if (ts_out_sop !== (hs == 0)) flags++;
                if (ts_out_eop !== (hs == NB - 1)) flags++;
                fin  = (ts_out_eop === 1'b1);
                hold = 1'b0;
                hs++;
            end else begin
                hold = 1'b1;
                held = {ts_out_data, ts_out_sop, ts_out_eop};
            end
            tick();
        end
        ts_out_ready = 1'b0;
        exp_cnt = exp_cnt + 1'b1;

        for (int i = 0; i < got.size() && i < NB; i++)
            if (got[i] !== pl[i]) mism++;

        check("valid_drop", 32'(ts_out_valid), 32'd0);
        check("pkt_cnt", 32'(pkt_cnt), 32'(exp_cnt));
        check("hs_cnt", hs, NB);
        check("bytes", mism, 32'd0);
        check("sop_eop", flags, 32'd0);
        check("stable", unstable, 32'd0);
        check("valid_gap", badv, 32'd0);
        check("no_err", err_seen - e0, 32'd0);
        check("tag_hold", pkt_tag, tag);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst              = 1'b1;
        payload_req_in   = 1'b0;
        chan_out_ack     = 1'b0;
        payload_in_valid = 1'b0;
        payload_in_start = 1'b0;
        payload_in_end   = 1'b0;
        payload_in_data  = '0;
        ts_out_ready     = 1'b0;
        repeat (3) tick();

        check("rst_req0", 32'(chan_out_req), 32'd0);
        check("rst_valid0", 32'(ts_out_valid), 32'd0);
        check("rst_err0", 32'(fetch_err), 32'd0);
        check("rst_cnt0", 32'(pkt_cnt), 32'd0);
        check("rst_tag0", pkt_tag, 32'd0);
        check("rst_flags0", 32'({ts_out_sop, ts_out_eop}), 32'd0);

        rst = 1'b0;
        tick();
        payload_req_in = 1'b1;

        fetch(K_GOOD, 1'b1, 0, -1);
        fetch(K_GOOD, 1'b0, 1, -1);
        fetch(K_SHORT, 1'b0, 0, -1);
        fetch(K_TIMEOUT, 1'b0, 0, -1);
        fetch(K_SYNC, 1'b0, 0, -1);
        fetch(K_GOOD, 1'b0, 2, 90);
        fetch(K_GOOD, 1'b0, 1, -1);

        for (int i = 0; i < 8; i++) begin
            k = $urandom_range(0, 9);
            if (k < 5)      fetch(K_GOOD, 1'b0, 2, -1);
            else if (k < 7) fetch(K_SHORT, 1'b0, 0, -1);
            else if (k < 8) fetch(K_SYNC, 1'b0, 0, -1);
            else            fetch(K_NOSTART, 1'b0, 0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
